// File: rtl/adder_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// adder_result_fifo : in-order FIFO for {co,sum} adder results with a
//                     saturating carry-event counter.   Rev 1.0
// ============================================================================
module adder_result_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     co,
   input  logic [3:0]               sum,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_co,
   output logic [3:0]               out_sum,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         carry_cnt,
   input  logic                     clr_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   logic [4:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CNT_W-1:0] r_carry_cnt;
   logic             r_out_co;
   logic [3:0]       r_out_sum;

   logic             w_push;
   logic             w_pop;
   logic [PTR_W-1:0] w_rd_next;
   logic [CW-1:0]    w_count_next;
   logic [4:0]       w_head_next;

   assign in_ready  = !rst && (r_count != CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // The head is kept in a register; when the next head slot is the one
   // being written this edge, forward the incoming entry instead of memory.
   always_comb begin
      w_rd_next    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
      w_head_next  = r_mem[w_rd_next];
      if (w_push && (w_rd_next == r_wr_ptr)) begin
         w_head_next = {co, sum};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {co, sum};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_carry_cnt <= '0;
         r_out_co    <= 1'b0;
         r_out_sum   <= 4'h0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         r_rd_ptr <= w_rd_next;
         r_count  <= w_count_next;
         if (w_count_next != '0) begin
            {r_out_co, r_out_sum} <= w_head_next;
         end
         if (clr_cnt) begin
            r_carry_cnt <= '0;
         end else if (w_push && co && (r_carry_cnt != '1)) begin
            r_carry_cnt <= r_carry_cnt + CNT_W'(1);
         end
      end
   end

   assign count     = r_count;
   assign carry_cnt = r_carry_cnt;
   assign out_co    = r_out_co;
   assign out_sum   = r_out_sum;
endmodule
`default_nettype wire

// File: tb/tb_adder_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for adder_result_fifo: directed vector table, hand sequences and
// random traffic checked against a queue-based reference model.
module tb_adder_result_fifo;
   localparam int DEPTH = 4;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic                   co = 1'b0;
   logic [3:0]             sum = 4'h0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic                   out_co;
   logic [3:0]             out_sum;
   logic [$clog2(DEPTH):0] count;
   logic [CNT_W-1:0]       carry_cnt;
   logic                   clr_cnt = 1'b0;

   adder_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .co(co), .sum(sum), .out_valid(out_valid), .out_ready(out_ready),
      .out_co(out_co), .out_sum(out_sum), .count(count),
      .carry_cnt(carry_cnt), .clr_cnt(clr_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: stored entries, carry counter, last presented head.
   logic [4:0] q[$];
   int         m_carry = 0;
   logic [4:0] m_head  = 5'h0;

   typedef struct {
      logic       v;
      logic       c;
      logic [3:0] s;
      logic       r;
      int         e_count;
      logic       e_ov;
      logic       e_co;
      logic [3:0] e_sum;
      int         e_carry;
   } vec_t;
   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("count",     32'(count),     32'(q.size()));
      chk("in_ready",  32'(in_ready),  32'(!rst && (q.size() < DEPTH)));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("out_co",    32'(out_co),    32'(m_head[4]));
      chk("out_sum",   32'(out_sum),   32'(m_head[3:0]));
      chk("carry_cnt", 32'(carry_cnt), 32'(m_carry));
   endtask

   task automatic step(input logic v, input logic c, input logic [3:0] s,
                       input logic r, input logic cl, input logic rs);
      int  pre;
      bit  acc_push;
      bit  acc_pop;
      in_valid = v; co = c; sum = s; out_ready = r; clr_cnt = cl; rst = rs;
      pre      = q.size();
      acc_push = !rs && v && (pre < DEPTH);
      acc_pop  = !rs && r && (pre > 0);
      @(posedge clk);
      if (rs) begin
         q.delete();
         m_carry = 0;
         m_head  = 5'h0;
      end else begin
         if (acc_pop)  void'(q.pop_front());
         if (acc_push) q.push_back({c, s});
         if (cl) m_carry = 0;
         else if (acc_push && c && m_carry < CMAX) m_carry++;
         if (q.size() != 0) m_head = q[0];
      end
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);
   endtask

   initial begin
      // Order/latency vectors: push 3, F... then drain; expectations hand-derived.
      vt[0] = '{1'b1, 1'b0, 4'h3, 1'b0, 1, 1'b1, 1'b0, 4'h3, 0};
      vt[1] = '{1'b1, 1'b1, 4'h2, 1'b0, 2, 1'b1, 1'b0, 4'h3, 1};
      vt[2] = '{1'b1, 1'b0, 4'hF, 1'b0, 3, 1'b1, 1'b0, 4'h3, 1};
      vt[3] = '{1'b0, 1'b0, 4'h0, 1'b1, 2, 1'b1, 1'b1, 4'h2, 1};
      vt[4] = '{1'b0, 1'b0, 4'h0, 1'b1, 1, 1'b1, 1'b0, 4'hF, 1};
      vt[5] = '{1'b0, 1'b0, 4'h0, 1'b1, 0, 1'b0, 1'b0, 4'hF, 1};

      #2;
      // Reset check
      do_reset();
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum",   32'(out_sum),   32'd0);
      chk("rst_carry",     32'(carry_cnt), 32'd0);

      // Order and latency
      for (int i = 0; i < 6; i++) begin
         step(vt[i].v, vt[i].c, vt[i].s, vt[i].r, 1'b0, 1'b0);
         chk("vec_count", 32'(count),     32'(vt[i].e_count));
         chk("vec_ov",    32'(out_valid), 32'(vt[i].e_ov));
         chk("vec_co",    32'(out_co),    32'(vt[i].e_co));
         chk("vec_sum",   32'(out_sum),   32'(vt[i].e_sum));
         chk("vec_carry", 32'(carry_cnt), 32'(vt[i].e_carry));
      end

      // Full boundary: 4 pushes, then offer A with a pop in the same cycle
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b0);
      chk("full_count", 32'(count),    32'd4);
      chk("full_ready", 32'(in_ready), 32'd0);
      step(1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0);
      chk("full_refused_count", 32'(count),    32'd3);
      chk("full_ready_back",    32'(in_ready), 32'd1);
      step(1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0);
      chk("full_reoffer_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("full_order", 32'(out_sum), 32'(i == 3 ? 4'hA : 4'(i + 2)));
         step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      end

      // Pointer wrap: 10 entries streamed with both sides always ready
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 4'(i), 1'b1, 1'b0, 1'b0);
         chk("wrap_count", 32'(count),   32'd1);
         chk("wrap_sum",   32'(out_sum), 32'(i));
      end
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("wrap_empty", 32'(out_valid), 32'd0);

      // Saturation and clear-wins
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      chk("sat_carry", 32'(carry_cnt), 32'(CMAX));
      step(1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0);
      chk("clr_wins", 32'(carry_cnt), 32'd0);

      // Reset mid-stream with push and pop offered
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'(i + 5), 1'b0, 1'b0, 1'b0);
      chk("mid_pre_count", 32'(count), 32'd3);
      step(1'b1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1);
      chk("mid_count", 32'(count),     32'd0);
      chk("mid_ov",    32'(out_valid), 32'd0);
      chk("mid_carry", 32'(carry_cnt), 32'd0);
      rst = 1'b0;
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("mid_no_ghost", 32'(out_valid), 32'd0);

      // Random traffic against the model; consumer speed varies by phase
      for (int i = 0; i < 600; i++) begin
         logic r;
         if (i < 200)      r = ($urandom_range(0, 3) == 0);
         else if (i < 400) r = ($urandom_range(0, 3) != 0);
         else              r = 1'($urandom_range(0, 1));
         step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), r,
              ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0));
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
